// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial-side signals of the PISO shift transmitter.
// master = word source / serial observer, slave = transmitter.
interface piso_shift_tx_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  frame_start,
        input  frame_end,
        input  busy
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        output ser_out,
        output ser_valid,
        output frame_start,
        output frame_end,
        output busy
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: captures a word on valid/ready and shifts it out
// one bit per clock with registered frame strobes and an optional inter-word gap.
module piso_shift_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned GAP       = 0
) (
    input logic            clock,
    input logic            clear,
    piso_shift_tx_if.slave bus
);
    localparam int unsigned     CntW      = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastIdx   = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] PenultIdx = CntW'(WIDTH - 2);
    localparam logic [3:0]      GapLast   = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
    logic             last_bit;
    logic             load_ready;
    logic             accept;

    // bit_cnt is the index of the bit currently on ser_out
    assign last_bit = (state_q == StShift) && (bit_cnt_q == LastIdx);

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q       <= StIdle;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StShift;
            end
            StShift: begin
                if (last_bit && !accept) state_d = (GAP > 0) ? StGap : StIdle;
            end
            StGap: begin
                if (gap_cnt_q == GapLast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load_ready    = !clear && ((state_q == StIdle) || (last_bit && (GAP == 0)));
        accept        = bus.load_valid && load_ready;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = '0;
        ser_out_d     = 1'b0;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        if (accept) begin
            // First bit goes straight to the output register; the rest wait in shift_q
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            bit_cnt_d     = '0;
            if (MSB_FIRST) begin
                ser_out_d = bus.data_in[WIDTH-1];
                shift_d   = {bus.data_in[WIDTH-2:0], 1'b0};
            end else begin
                ser_out_d = bus.data_in[0];
                shift_d   = {1'b0, bus.data_in[WIDTH-1:1]};
            end
        end else if ((state_q == StShift) && !last_bit) begin
            ser_valid_d = 1'b1;
            frame_end_d = (bit_cnt_q == PenultIdx);
            bit_cnt_d   = bit_cnt_q + CntW'(1);
            if (MSB_FIRST) begin
                ser_out_d = shift_q[WIDTH-1];
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            end else begin
                ser_out_d = shift_q[0];
                shift_d   = {1'b0, shift_q[WIDTH-1:1]};
            end
        end else if (state_q == StGap) begin
            gap_cnt_d = gap_cnt_q + 4'd1;
        end
    end

    assign bus.load_ready  = load_ready;
    assign bus.ser_out     = ser_out_q;
    assign bus.ser_valid   = ser_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.busy        = (state_q != StIdle);
endmodule
